// File: rtl/fillmem_dbuf.sv
// fillmem_dbuf: packs a stream of adjacency words into DDR lines.
// Double-buffered: one line collects while the previous waits on DDR.
module fillmem_dbuf #(
  parameter int IN_WIDTH   = 32,
  parameter int MEM_WIDTH  = 128,
  parameter int ADDR_BITS  = 25,
  parameter int PROB_BITS  = 4,
  parameter int VERTS_BITS = 10
) (
  input  logic                            i_clk150,
  input  logic                            i_reset,
  input  logic [IN_WIDTH-1:0]             i_indata,
  input  logic                            i_indata_have,
  output logic                            o_indata_want,
  input  logic                            i_go,
  input  logic                            i_abort,
  input  logic                            i_ignore_prob,
  input  logic [PROB_BITS-1:0]            i_prob_no,
  input  logic [VERTS_BITS-1:0]           i_nverts,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [ADDR_BITS-1:0]            o_ddr_waddr,
  output logic [MEM_WIDTH-1:0]            o_ddr_wdata,
  output logic [MEM_WIDTH/IN_WIDTH-1:0]   o_ddr_wbe,
  output logic                            o_ddr_wlast,
  output logic                            o_ddr_wdata_have,
  input  logic                            i_ddr_wdata_accept
);

  localparam int WPL = MEM_WIDTH / IN_WIDTH;
  localparam int CW  = 2 * VERTS_BITS;
  localparam int LW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int ZB  = ADDR_BITS - PROB_BITS;

  localparam logic [CW-1:0] C_IW   = CW'(IN_WIDTH);
  localparam logic [CW-1:0] C_WPL  = CW'(WPL);
  localparam logic [LW-1:0] C_LMAX = LW'(WPL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_IGNORE,
    S_FILL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [VERTS_BITS-1:0] r_nverts;
  logic [PROB_BITS-1:0]  r_prob;
  logic                  r_ign;
  logic [CW-1:0]         r_words;
  logic [CW-1:0]         r_lines;
  logic [ADDR_BITS-1:0]  r_base;
  logic [CW-1:0]         r_rcvd;
  logic [CW-1:0]         r_line;
  logic [LW-1:0]         r_lane;
  logic                  r_done;

  logic [MEM_WIDTH-1:0]  r_col;
  logic [WPL-1:0]        r_col_be;
  logic                  r_col_full;

  logic                  r_out_valid;
  logic [MEM_WIDTH-1:0]  r_out_data;
  logic [WPL-1:0]        r_out_be;
  logic [ADDR_BITS-1:0]  r_out_addr;
  logic                  r_out_last;

  logic [CW-1:0]         w_prod;
  logic [CW-1:0]         w_words;
  logic [CW-1:0]         w_lines;
  logic                  w_want;
  logic                  w_in_xfer;
  logic                  w_acc;
  logic                  w_out_free;
  logic                  w_last_word;
  logic                  w_word_done;
  logic                  w_move_new;
  logic                  w_move_held;
  logic                  w_move;
  logic                  w_abort;
  logic [MEM_WIDTH-1:0]  w_col_nx;
  logic [WPL-1:0]        w_be_nx;
  logic [MEM_WIDTH-1:0]  w_mv_data;
  logic [WPL-1:0]        w_mv_be;

  // Word and line counts from the latched vertex count.
  assign w_prod  = {{VERTS_BITS{1'b0}}, r_nverts}
                 * {{VERTS_BITS{1'b0}}, r_nverts};
  assign w_words = (w_prod / C_IW)
                 + CW'((w_prod % C_IW) != '0);
  assign w_lines = (w_words / C_WPL)
                 + CW'((w_words % C_WPL) != '0);

  assign w_want = (r_state == S_IGNORE)
               || ((r_state == S_FILL)
                   && !r_col_full
                   && (r_rcvd < r_words));

  assign w_in_xfer   = w_want && i_indata_have;
  assign w_acc       = r_out_valid && i_ddr_wdata_accept;
  assign w_out_free  = !r_out_valid || w_acc;
  assign w_last_word = (r_rcvd + CW'(1)) == r_words;
  assign w_abort     = i_abort
                    && (r_state != S_IDLE)
                    && (r_state != S_DONE);

  assign w_word_done = w_in_xfer
                    && (r_state == S_FILL)
                    && ((r_lane == C_LMAX) || w_last_word);
  assign w_move_new  = w_word_done && w_out_free;
  assign w_move_held = r_col_full && w_out_free;
  assign w_move      = w_move_new || w_move_held;

  always_comb begin
    w_col_nx = r_col;
    w_col_nx[int'(r_lane)*IN_WIDTH +: IN_WIDTH] = i_indata;
    w_be_nx  = r_col_be | (WPL'(1) << r_lane);
  end

  // A held line is already complete; otherwise include the arriving word.
  assign w_mv_data = r_col_full ? r_col    : w_col_nx;
  assign w_mv_be   = r_col_full ? r_col_be : w_be_nx;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_go) w_state_nx = S_SETUP;
      S_SETUP:
        if (w_words == '0)
          w_state_nx = S_DONE;
        else if (r_ign)
          w_state_nx = S_IGNORE;
        else
          w_state_nx = S_FILL;
      S_IGNORE:
        if (w_in_xfer && w_last_word)
          w_state_nx = S_DONE;
      S_FILL:
        if (w_acc && r_out_last)
          w_state_nx = S_DONE;
      S_DONE:
        w_state_nx = S_IDLE;
      default:
        w_state_nx = S_IDLE;
    endcase
    if (w_abort) w_state_nx = S_IDLE;
  end

  always_ff @(posedge i_clk150 or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= (w_state_nx == S_DONE) || w_abort;
    end
  end

  always_ff @(posedge i_clk150 or posedge i_reset) begin
    if (i_reset) begin
      r_nverts    <= '0;
      r_prob      <= '0;
      r_ign       <= 1'b0;
      r_words     <= '0;
      r_lines     <= '0;
      r_base      <= '0;
      r_rcvd      <= '0;
      r_line      <= '0;
      r_lane      <= '0;
      r_col       <= '0;
      r_col_be    <= '0;
      r_col_full  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_be    <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_abort) begin
      r_words     <= '0;
      r_lines     <= '0;
      r_rcvd      <= '0;
      r_line      <= '0;
      r_lane      <= '0;
      r_col       <= '0;
      r_col_be    <= '0;
      r_col_full  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_be    <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_go) begin
        r_nverts <= i_nverts;
        r_prob   <= i_prob_no;
        r_ign    <= i_ignore_prob;
      end

      if (r_state == S_SETUP) begin
        r_words <= w_words;
        r_lines <= w_lines;
        r_base  <= {r_prob, {ZB{1'b0}}};
        r_rcvd  <= '0;
        r_line  <= '0;
        r_lane  <= '0;
      end

      if (w_in_xfer) r_rcvd <= r_rcvd + CW'(1);

      if (w_word_done) begin
        r_lane <= '0;
        if (w_out_free) begin
          r_col    <= '0;
          r_col_be <= '0;
        end else begin
          r_col      <= w_col_nx;
          r_col_be   <= w_be_nx;
          r_col_full <= 1'b1;
        end
      end else if (w_in_xfer && r_state == S_FILL) begin
        r_col    <= w_col_nx;
        r_col_be <= w_be_nx;
        r_lane   <= r_lane + LW'(1);
      end else if (w_move_held) begin
        r_col      <= '0;
        r_col_be   <= '0;
        r_col_full <= 1'b0;
      end

      if (w_move) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mv_data;
        r_out_be    <= w_mv_be;
        r_out_addr  <= r_base + ADDR_BITS'(r_line);
        r_out_last  <= (r_line == r_lines - CW'(1));
        r_line      <= r_line + CW'(1);
      end else if (w_acc) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_be    <= '0;
        r_out_addr  <= '0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign o_indata_want    = w_want;
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = r_done;
  assign o_ddr_waddr      = r_out_addr;
  assign o_ddr_wdata      = r_out_data;
  assign o_ddr_wbe        = r_out_be;
  assign o_ddr_wlast      = r_out_last;
  assign o_ddr_wdata_have = r_out_valid;

endmodule

// File: tb/tb_fillmem_dbuf.sv
// tb_fillmem_dbuf: scoreboard bench for fillmem_dbuf.
// Expected lines are queued at go and popped on each DDR accept.
module tb_fillmem_dbuf;

  localparam int IW  = 32;
  localparam int MW  = 128;
  localparam int AB  = 25;
  localparam int PB  = 4;
  localparam int VB  = 10;
  localparam int WPL = MW / IW;

  logic          i_clk150 = 1'b0;
  logic          i_reset  = 1'b1;
  logic [IW-1:0] i_indata;
  logic          i_indata_have;
  logic          o_indata_want;
  logic          i_go;
  logic          i_abort;
  logic          i_ignore_prob;
  logic [PB-1:0] i_prob_no;
  logic [VB-1:0] i_nverts;
  logic          o_busy;
  logic          o_done;
  logic [AB-1:0] o_ddr_waddr;
  logic [MW-1:0] o_ddr_wdata;
  logic [WPL-1:0] o_ddr_wbe;
  logic          o_ddr_wlast;
  logic          o_ddr_wdata_have;
  logic          i_ddr_wdata_accept;

  always #3 i_clk150 = ~i_clk150;

  fillmem_dbuf dut (
    .i_clk150          (i_clk150),
    .i_reset           (i_reset),
    .i_indata          (i_indata),
    .i_indata_have     (i_indata_have),
    .o_indata_want     (o_indata_want),
    .i_go              (i_go),
    .i_abort           (i_abort),
    .i_ignore_prob     (i_ignore_prob),
    .i_prob_no         (i_prob_no),
    .i_nverts          (i_nverts),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_ddr_waddr       (o_ddr_waddr),
    .o_ddr_wdata       (o_ddr_wdata),
    .o_ddr_wbe         (o_ddr_wbe),
    .o_ddr_wlast       (o_ddr_wlast),
    .o_ddr_wdata_have  (o_ddr_wdata_have),
    .i_ddr_wdata_accept(i_ddr_wdata_accept)
  );

  typedef struct {
    logic [AB-1:0]  addr;
    logic [MW-1:0]  data;
    logic [WPL-1:0] be;
    logic           last;
  } line_t;

  line_t sb[$];

  int n_vec = 0;
  int n_bad = 0;
  int done_at, acc_last_at, first_in, last_in;
  int in_at_stall, abort_cyc, writes;
  bit want_seen, have_seen, want_at_stall;

  task automatic chk(input string tag,
                     input logic [MW-1:0] got,
                     input logic [MW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n, input int prob, input bit ign,
                     input int stall, input int abort_at);
    int w, l, idx, cyc, nexp;
    bit ab, ab_done;
    logic [IW-1:0] words[$];
    line_t e;
    w = (n * n + IW - 1) / IW;
    l = (w + WPL - 1) / WPL;
    words.delete();
    for (int i = 0; i < w; i++) words.push_back($urandom);
    nexp = ign ? 0 : ((abort_at > 0) ? 1 : l);
    for (int k = 0; k < nexp; k++) begin
      e.addr = AB'(prob) << (AB - PB);
      e.addr = e.addr + AB'(k);
      e.data = '0;
      e.be   = '0;
      e.last = (k == l - 1);
      for (int j = 0; j < WPL; j++)
        if (k * WPL + j < w) begin
          e.data[j*IW +: IW] = words[k*WPL + j];
          e.be[j] = 1'b1;
        end
      sb.push_back(e);
    end
    done_at = 0; acc_last_at = -1; first_in = -1; last_in = -1;
    in_at_stall = -1; abort_cyc = -1; writes = 0;
    want_seen = 0; have_seen = 0; want_at_stall = 1;
    @(negedge i_clk150);
    i_go = 1'b1;
    i_nverts = VB'(n);
    i_prob_no = PB'(prob);
    i_ignore_prob = ign;
    idx = 0; cyc = 0; ab = 0; ab_done = 0;
    while (cyc < 3000) begin
      @(negedge i_clk150);
      cyc++;
      i_go = 1'b0;
      i_ignore_prob = 1'b0;
      ab = (abort_at > 0) && (idx >= abort_at) && !ab_done;
      i_abort = ab;
      i_indata_have = (idx < w) && !((abort_at > 0) && (idx >= abort_at));
      i_indata = i_indata_have ? words[idx] : '0;
      i_ddr_wdata_accept = ab || ((abort_at == 0) && (cyc > stall));
      #1;
      if (o_done) begin
        done_at = cyc;
        if (abort_at > 0) begin
          chk("abort_busy", o_busy, 0);
          chk("abort_have", o_ddr_wdata_have, 0);
          chk("abort_done_lat", done_at - abort_cyc, 1);
        end
        break;
      end
      if (o_indata_want) want_seen = 1;
      if (o_ddr_wdata_have) have_seen = 1;
      if (o_indata_want && i_indata_have) begin
        if (first_in < 0) first_in = cyc;
        last_in = cyc;
        idx++;
      end
      if (cyc == stall) begin
        in_at_stall = idx;
        want_at_stall = o_indata_want;
      end
      if (o_ddr_wdata_have && i_ddr_wdata_accept) begin
        writes++;
        acc_last_at = cyc;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("waddr", o_ddr_waddr, e.addr);
          chk("wdata", o_ddr_wdata, e.data);
          chk("wbe", o_ddr_wbe, e.be);
          chk("wlast", o_ddr_wlast, e.last);
        end
      end
      if (ab) begin
        ab_done = 1;
        abort_cyc = cyc;
      end
    end
    i_indata_have = 1'b0;
    i_indata = '0;
    i_abort = 1'b0;
    i_ddr_wdata_accept = 1'b0;
    chk("done_seen", done_at > 0, 1);
    chk("words_taken", idx, (abort_at > 0) ? abort_at : w);
    chk("write_count", writes, nexp);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    repeat (3) begin
      @(negedge i_clk150);
      #1;
      if (o_ddr_wdata_have) have_seen = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_indata = '0;
    i_indata_have = 1'b0;
    i_go = 1'b0;
    i_abort = 1'b0;
    i_ignore_prob = 1'b0;
    i_prob_no = '0;
    i_nverts = '0;
    i_ddr_wdata_accept = 1'b0;
    repeat (3) @(negedge i_clk150);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_want", o_indata_want, 0);
    chk("rst_have", o_ddr_wdata_have, 0);
    chk("rst_waddr", o_ddr_waddr, 0);
    chk("rst_wdata", o_ddr_wdata, 0);
    chk("rst_wbe", o_ddr_wbe, 0);
    chk("rst_wlast", o_ddr_wlast, 0);
    i_reset = 1'b0;
    @(negedge i_clk150);

    run(10, 3, 0, 0, 0);
    chk("n10_done_lat", done_at - acc_last_at, 1);

    run(12, 3, 0, 0, 0);
    chk("n12_stream", last_in - first_in, 4);

    run(0, 5, 0, 0, 0);
    chk("n0_want", want_seen, 0);
    chk("n0_have", have_seen, 0);
    chk("n0_done_at", done_at, 2);

    run(64, 7, 0, 20, 0);
    chk("stall_words", in_at_stall, 8);
    chk("stall_want", want_at_stall, 0);

    run(64, 9, 1, 0, 0);
    chk("ign_have", have_seen, 0);
    chk("ign_stream", last_in - first_in, 127);
    chk("ign_done_lat", done_at - last_in, 1);

    run(20, 1, 0, 0, 0);
    chk("n20_stream", last_in - first_in, 12);

    run(64, 2, 0, 0, 6);
    chk("abort_quiet", have_seen, 1);

    run(10, 3, 0, 0, 0);
    chk("restart_done_lat", done_at - acc_last_at, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fillmem_dbuf.md
Name: fillmem_dbuf

Overview:
Parametrised, double-buffered successor to the problem-matrix loader. It receives a stream of IN_WIDTH-bit adjacency words for one problem of i_nverts vertices and packs them into MEM_WIDTH-bit DDR lines. It writes the lines to consecutive addresses in that problem's DDR slot. One line can be collected while the previous line waits on DDR, and the block adds ignore, abort and partial-line byte-enable support.

Parameters:
IN_WIDTH, 32, input word width in bits; MEM_WIDTH must be an integer multiple of it.
MEM_WIDTH, 128, DDR line width in bits.
ADDR_BITS, 25, DDR line address width.
PROB_BITS, 4, problem-slot bits forming the top of the address.
VERTS_BITS, 10, width of i_nverts.
Derived: WPL = MEM_WIDTH/IN_WIDTH words per line.

Ports:
i_clk150  in  1  clock
i_reset  in  1  reset
i_indata  in  IN_WIDTH  input word
i_indata_have  in  1  input word valid
o_indata_want  out  1  block can take a word
i_go  in  1  start pulse, sampled only in IDLE
i_abort  in  1  terminate current problem
i_ignore_prob  in  1  consume without writing, sampled with i_go
i_prob_no  in  PROB_BITS  problem slot, sampled with i_go
i_nverts  in  VERTS_BITS  vertex count, sampled with i_go
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle completion pulse
o_ddr_waddr  out  ADDR_BITS  line address
o_ddr_wdata  out  MEM_WIDTH  line data
o_ddr_wbe  out  WPL  per-input-word enable
o_ddr_wlast  out  1  marks the final line of the problem
o_ddr_wdata_have  out  1  write request
i_ddr_wdata_accept  in  1  write accepted

Behaviour:
- Reset: i_reset, asynchronous, active-high; clock i_clk150. All outputs go to 0 and state to IDLE. Buffers are zeroed.
- Transfers:
  - An input word transfers when o_indata_want and i_indata_have are both high.
  - A DDR write completes when o_ddr_wdata_have and i_ddr_wdata_accept are both high.
  - Once o_ddr_wdata_have rises, o_ddr_waddr, o_ddr_wdata, o_ddr_wbe and o_ddr_wlast stay stable until accept.
- Word count: W = ceil(n*n / IN_WIDTH), n = i_nverts.
  - Computed in registered SETUP, one cycle after go.
  - Product width is 2*VERTS_BITS, with no overflow.
  - Number of lines L = ceil(W / WPL).
- Base address: {i_prob_no, zeros}. Line k is written to base + k.
- States:
  - IDLE: wait for i_go.
  - SETUP: latch W, L and base. If W==0, go to DONE. Otherwise go to IGNORE if the ignore flag was sampled, else to FILL.
  - IGNORE: o_indata_want=1; count W words with no DDR activity, then go to DONE.
  - FILL: covers both collect and write.
  - DONE: o_done=1 for one cycle, then return to IDLE.
- FILL, collect buffer:
  - Input word j goes into lane j mod WPL; lane 0 occupies bits [IN_WIDTH-1:0].
  - A line is complete at WPL words or at word W.
  - When complete: if the output register is empty, or is being accepted in the same cycle, the line moves there and the collect buffer is zeroed. Otherwise the line is held.
- FILL, o_indata_want: high when the collect buffer is not holding a full line and fewer than W words have been received.
- FILL, output register: drives o_ddr_*.
  - o_ddr_wbe has bit i set for each received lane.
  - o_ddr_wlast=1 on line L-1.
  - Unused lanes are 0.
- FILL exit: after the accept of line L-1, go to DONE.
- Simultaneous events: a word arriving, a line handoff and a DDR accept can all happen in one cycle, with no bubble. Sustained throughput is one word per cycle when accept is always high.
- i_abort, any non-IDLE state:
  - Next cycle returns to IDLE and all counters and buffers clear.
  - o_done pulses and o_ddr_wdata_have drops.
  - An abort in the same cycle as an accept still counts that line as written.
  - i_abort in IDLE is ignored.
- i_go outside IDLE is ignored.
- Reset mid-operation behaves like power-up, with no pending write retained.

Test Plan:
- IN=32, MEM=128, n=10, prob=3, accept always high -> W=4, one write at addr 0x600000, wbe=1111, wlast=1, o_done 1 cycle after accept.
- n=12 -> W=5, two writes at 0x600000 and 0x600001; second line has lane0=word4, lanes1-3=0, wbe=0001, wlast=1.
- n=0, go -> no o_indata_want, no writes, o_done pulses 2 cycles after go.
- n=64, accept low for 20 cycles, input always valid -> exactly 8 words accepted, then o_indata_want=0. After accept is released, all 128 words are taken and 32 sequential addresses written.
- n=64, i_ignore_prob=1 -> 128 words consumed back-to-back, o_ddr_wdata_have never asserts, o_done follows the last word.
- Abort after 6 words, with line 0 pending and accept coinciding -> line 0 counted, no further writes, o_done pulse, a new go restarts correctly.
